// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Byte distance between consecutive instruction words.
    function automatic int pc_step(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous prefetch FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_C   = (PW + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign count     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[PW-1:0]];
    assign pop_ok_s  = pop && (count != {(PW + 1){1'b0}});
    assign push_ok_s = push && ((count != DEPTH_C) || pop_ok_s);

    // Pointer update; flush empties the queue regardless of push/pop.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= {(PW + 1){1'b0}};
            rd_ptr_r <= {(PW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push_ok_s && !reset && !flush) begin
            mem_r[wr_ptr_r[PW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding memory requests and
// queues returned instructions with their PC for decode.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_instr,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [ADDR_WIDTH-1:0]     out_pc_next,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int                    STEP       = pc_step(DATA_WIDTH);
    localparam int                    CW         = $clog2(DEPTH) + 1;
    localparam int                    FW         = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STEP - 1));
    localparam logic [CW-1:0]         DEPTH_C    = CW'(DEPTH);

    fetch_state_e            state_r;
    fetch_state_e            state_nxt_s;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r;
    logic [ADDR_WIDTH-1:0]   fetch_pc_nxt_s;
    logic [ADDR_WIDTH-1:0]   req_pc_r;
    logic [ADDR_WIDTH-1:0]   req_pc_nxt_s;
    logic                    handshake_s;
    logic                    push_s;
    logic                    pop_s;
    logic [CW-1:0]           count_s;
    logic [FW-1:0]           head_s;

    // Requests depend only on registered state; the reset gate keeps the bus idle while held.
    assign mem_req     = !reset && (state_r == ST_RUN) && (count_s < DEPTH_C);
    assign mem_addr    = fetch_pc_r;
    assign handshake_s = mem_req && mem_gnt;

    assign fifo_count  = count_s;
    assign out_valid   = (count_s != {CW{1'b0}});
    assign pop_s       = out_valid && out_ready && !redirect_valid;
    assign out_instr   = out_valid ? head_s[FW-1 -: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    assign out_pc      = out_valid ? head_s[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
    assign out_pc_next = out_pc + STEP_A;

    // Next-state, PC and push decode; a redirect overrides the normal transition.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        req_pc_nxt_s   = req_pc_r;
        push_s         = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (handshake_s) begin
                    state_nxt_s    = ST_WAIT;
                    fetch_pc_nxt_s = fetch_pc_r + STEP_A;
                    req_pc_nxt_s   = fetch_pc_r;
                end else begin
                    state_nxt_s    = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_RUN;
                    push_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase

        // A response still owed after this cycle must be swallowed in DISCARD.
        if (redirect_valid) begin
            push_s         = 1'b0;
            fetch_pc_nxt_s = redirect_pc & ALIGN_MASK;
            case (state_r)
                ST_RUN:             state_nxt_s = handshake_s ? ST_DISCARD : ST_RUN;
                ST_WAIT, ST_DISCARD: state_nxt_s = mem_rvalid ? ST_RUN : ST_DISCARD;
                default:            state_nxt_s = ST_RUN;
            endcase
        end else begin
            push_s = push_s;
        end
    end

    // State, fetch PC and outstanding-request PC registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_RUN;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            req_pc_r   <= req_pc_nxt_s;
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_s),
        .wr_data ({mem_rdata, req_pc_r}),
        .pop     (pop_s),
        .flush   (redirect_valid),
        .count   (count_s),
        .head    (head_s)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: memory model plus in-order scoreboard.
module tb_fetch_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  fifo_count;

    fetch_prefetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_next    (out_pc_next),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .fifo_count     (fifo_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // per-cycle stimulus controls
    logic        rst_v = 1'b1;
    logic        ready_v = 1'b0;
    logic        gnt_v = 1'b1;
    logic        redir_v = 1'b0;
    logic [31:0] redir_pc_v = 32'h0;
    int          lat_v = 1;

    // memory model state
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    int          pop_cnt = 0;
    int          grant_cnt = 0;
    logic [31:0] first_pop_pc = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive inputs after the falling edge, log handshakes, advance.
    task automatic tick();
        exp_t e;
        reset          = rst_v;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc_v;
        out_ready      = ready_v;
        mem_gnt        = gnt_v;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        if (pend && pend_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mdata(pend_addr);
            pend       = 1'b0;
        end else if (pend) begin
            pend_cnt--;
        end
        #1;
        if (!reset) begin
            if (out_valid && out_ready && !redirect_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: emitted pc=%h instr=%h, required no output", out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e.pc || out_instr !== e.instr || out_pc_next !== e.pc + 32'd4) begin
                        n_errors++;
                        $display("FAIL sb_entry: got pc=%h instr=%h next=%h, required pc=%h instr=%h next=%h",
                                 out_pc, out_instr, out_pc_next, e.pc, e.instr, e.pc + 32'd4);
                    end
                end
                if (pop_cnt == 0) first_pop_pc = out_pc;
                pop_cnt++;
            end
            if (mem_req && mem_gnt) begin
                grant_cnt++;
                pend      = 1'b1;
                pend_cnt  = lat_v - 1;
                pend_addr = mem_addr;
                if (!redirect_valid) begin
                    e.pc    = mem_addr;
                    e.instr = mdata(mem_addr);
                    sb.push_back(e);
                end
            end
            if (redirect_valid) sb.delete();
        end else begin
            sb.delete();
            pend = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        redir_v = 1'b0;
    endtask

    task automatic apply_reset();
        rst_v   = 1'b1;
        ready_v = 1'b0;
        gnt_v   = 1'b1;
        lat_v   = 1;
        repeat (2) tick();
        rst_v = 1'b0;
        reset = 1'b0;
        #1;
        pop_cnt   = 0;
        grant_cnt = 0;
    endtask

    task automatic test_reset();
        rst_v = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({mem_req, out_valid, fifo_count} !== {1'b0, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_ctrl: req/valid/count=%b/%b/%0d, required 0/0/0", mem_req, out_valid, fifo_count);
        end
        n_checks++;
        if ({mem_addr, out_instr, out_pc, out_pc_next} !== {32'h100, 32'h0, 32'h0, 32'h4}) begin
            n_errors++;
            $display("FAIL reset_data: addr=%h instr=%h pc=%h next=%h, required 100/0/0/4",
                     mem_addr, out_instr, out_pc, out_pc_next);
        end
        rst_v = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL first_req: req=%b addr=%h, required 1 and 00000100", mem_req, mem_addr);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        ready_v = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_wait: valid=%b req=%b, required 0/0", out_valid, mem_req);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL stream_latency: valid=%b pc=%h req=%b, required 1/00000100/1", out_valid, out_pc, mem_req);
        end
        repeat (10) tick();
        n_checks++;
        if (pop_cnt != 5) begin
            n_errors++;
            $display("FAIL stream_rate: pops=%0d, required 5", pop_cnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        repeat (12) tick();
        n_checks++;
        if (grant_cnt != 4 || fifo_count !== 3'd4 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: grants=%0d count=%0d req=%b, required 4/4/0", grant_cnt, fifo_count, mem_req);
        end
        ready_v = 1'b1;
        tick();
        ready_v = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (grant_cnt != 5 || fifo_count !== 3'd4 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_refill: grants=%0d count=%0d req=%b, required 5/4/0", grant_cnt, fifo_count, mem_req);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        ready_v = 1'b1;
        lat_v   = 4;
        tick();
        redir_v    = 1'b1;
        redir_pc_v = 32'h0000_0202;
        lat_v      = 1;
        tick();
        n_checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL discard_idle: req=%b valid=%b, required 0/0", mem_req, out_valid);
        end
        repeat (3) tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200 || fifo_count !== 3'd0) begin
            n_errors++;
            $display("FAIL discard_drop: req=%b addr=%h count=%0d, required 1/00000200/0", mem_req, mem_addr, fifo_count);
        end
        repeat (6) tick();
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'h200) begin
            n_errors++;
            $display("FAIL redirect_target: pops=%0d first_pc=%h, required >0 and 00000200", pop_cnt, first_pop_pc);
        end
    endtask

    task automatic test_flush_same_cycle();
        apply_reset();
        repeat (5) tick();
        n_checks++;
        if (fifo_count !== 3'd2) begin
            n_errors++;
            $display("FAIL flush_setup: count=%0d, required 2", fifo_count);
        end
        ready_v    = 1'b1;
        redir_v    = 1'b1;
        redir_pc_v = 32'h0000_0300;
        tick();
        n_checks++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0 || pop_cnt != 0) begin
            n_errors++;
            $display("FAIL flush_clear: count=%0d valid=%b pops=%0d, required 0/0/0", fifo_count, out_valid, pop_cnt);
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_errors++;
            $display("FAIL flush_restart: req=%b addr=%h, required 1/00000300", mem_req, mem_addr);
        end
        repeat (8) tick();
        n_checks++;
        if (first_pop_pc !== 32'h300) begin
            n_errors++;
            $display("FAIL flush_target: first_pc=%h, required 00000300", first_pop_pc);
        end
    endtask

    task automatic test_stall_wrap();
        apply_reset();
        ready_v = 1'b1;
        gnt_v   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h, required 1/00000100", i, mem_req, mem_addr);
            end
        end
        redir_v    = 1'b1;
        redir_pc_v = 32'hFFFF_FFFC;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_redirect: req=%b addr=%h, required 1/fffffffc", mem_req, mem_addr);
        end
        gnt_v = 1'b1;
        tick();
        n_checks++;
        if (mem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_pc: addr=%h, required 00000000", mem_addr);
        end
        pop_cnt = 0;
        repeat (4) tick();
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_out: pops=%0d first_pc=%h, required >0 and fffffffc", pop_cnt, first_pop_pc);
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        repeat (5) tick();
        n_checks++;
        if (fifo_count !== 3'd2 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rstw_setup: count=%0d req=%b, required 2/0", fifo_count, mem_req);
        end
        rst_v = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, out_valid, fifo_count, mem_addr, out_instr, out_pc, out_pc_next}
            !== {1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h4}) begin
            n_errors++;
            $display("FAIL rstw_values: req=%b valid=%b count=%0d addr=%h instr=%h pc=%h next=%h, required 0/0/0/100/0/0/4",
                     mem_req, out_valid, fifo_count, mem_addr, out_instr, out_pc, out_pc_next);
        end
        rst_v   = 1'b0;
        ready_v = 1'b1;
        pop_cnt = 0;
        repeat (4) tick();
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'h100) begin
            n_errors++;
            $display("FAIL rstw_restart: pops=%0d first_pc=%h, required >0 and 00000100", pop_cnt, first_pop_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_flush_same_cycle();
        test_stall_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
# fetch_prefetch_unit

Parametrised instruction-fetch stage with a prefetch queue. It owns the program counter, issues word-aligned fetch requests to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PC in a DEPTH-entry FIFO. It supports decode-side backpressure and pipeline redirects (branch/jump/exception) that flush the queue and discard in-flight responses. It replaces the single-cycle PC/adder/address-mux fetch path of the multicycle datapath.

## Interface
- DATA_WIDTH, 32, instruction/memory word width; multiple of 8
- ADDR_WIDTH, 32, PC and memory address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset; DATA_WIDTH/8-aligned
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  head PC
- out_pc_next  out  ADDR_WIDTH  out_pc + DATA_WIDTH/8, modulo 2^ADDR_WIDTH
- mem_req  out  1  fetch request
- mem_addr  out  ADDR_WIDTH  request address
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response data valid
- mem_rdata  in  DATA_WIDTH  response data
- fifo_count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- fetch_pc: next address to request. Request handshake completes when mem_req && mem_gnt; then fetch_pc += DATA_WIDTH/8 (wraps at 2^ADDR_WIDTH).
- At most one outstanding request. Response returns ≥1 cycle after grant, in order, exactly one mem_rvalid per grant.
- Space reservation: mem_req asserted only when state is RUN and fifo_count + outstanding < DEPTH (outstanding is 0 in RUN). Response write can never overflow.
- While mem_req is high and no redirect occurs, mem_addr stays stable until granted.
- FSM (enum in package):
  - RUN: no outstanding. mem_req = space available. Grant → WAIT.
  - WAIT: one outstanding. mem_rvalid → push {mem_rdata, pc of request}, → RUN.
  - DISCARD: one outstanding whose response is dropped. mem_rvalid → RUN, nothing pushed.
- Redirect (highest priority, any state): FIFO cleared, fetch_pc ← redirect_pc, pop and push that cycle ignored. Next state: DISCARD if a request is outstanding after this cycle (state WAIT without mem_rvalid, or RUN with mem_req && mem_gnt this cycle); else RUN. In DISCARD, redirect updates fetch_pc only and stays in DISCARD (unless mem_rvalid same cycle → RUN).
- Pop: out_valid && out_ready && !redirect_valid. Push and pop same cycle permitted at any occupancy, count unchanged.
- Reset: state RUN, fetch_pc ← RESET_PC, FIFO empty; any response arriving after reset is ignored (memory is reset with this block).

## Timing
- Reset values: mem_req 0, mem_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, out_pc_next DATA_WIDTH/8, fifo_count 0.
- First cycle with reset low: mem_req 1, mem_addr RESET_PC.
- mem_req, mem_addr are combinational from registered state only (no path from mem_gnt/mem_rvalid).
- rvalid in cycle N → out_valid high in N+1 (registered FIFO, no bypass).
- Grant in N with 1-cycle memory: rvalid N+1, next mem_req N+2; sustained throughput 1 instruction / 2 cycles.
- Redirect in N: out_valid 0 in N+1; mem_addr = redirect_pc in N+1 if state RUN.
- out_* outputs registered/FIFO-head, no combinational path from out_ready.

## Structure
- fetch_pkg: state enum (RUN, WAIT, DISCARD), PC_STEP function of DATA_WIDTH.
- Sub-module fetch_fifo: synchronous FIFO, parameters WIDTH (= DATA_WIDTH+ADDR_WIDTH), DEPTH; ports push, pop, flush, count, head; wrap-around pointers with extra bit.
- Top holds FSM, fetch_pc, outstanding-PC register.

## Test plan
- Reset, RESET_PC=0x100, mem_gnt=1, 1-cycle memory, out_ready=1 → out_pc sequence 0x100, 0x104, 0x108 with matching data, out_pc_next = out_pc+4.
- out_ready=0, DEPTH=4 → exactly 4 grants, fifo_count=4, mem_req stays 0; one pop → exactly one new request.
- Redirect to 0x200 while in WAIT, response arrives 3 cycles later → response dropped, next out_pc 0x200.
- Redirect and push and pop in the same cycle with FIFO at 2 → fifo_count 0 next cycle, nothing emitted.
- mem_gnt held low 5 cycles → mem_req high, mem_addr constant throughout; fetch_pc 0xFFFF_FFFC → next fetch 0x0000_0000.
- Reset asserted in WAIT with 2 entries queued → next cycle outputs at reset values, fetch restarts at RESET_PC.
